lifo_stack_ctl: RTL and testbench
=================================

# lifo_stack_ctl

Parametrised last-in-first-out buffer with configurable width and depth, an occupancy count and a programmable almost-full threshold. It supports a simultaneous push and pop in one cycle as a top-of-stack replace, and exposes a combinational peek of the current top entry. It sits between a producer and consumer in the datapath wherever scratch storage, return-address style nesting or undo buffering is needed, and is the standard stack primitive for new blocks.

## Interface
- DATA_WIDTH, 8, entry width in bits
- LIFO_DEPTH, 16, number of entries; any value ≥ 2, not restricted to powers of two
- AF_LEVEL, LIFO_DEPTH-2, ALMOST_FULL asserts when COUNT ≥ AF_LEVEL
- CW (localparam), $clog2(LIFO_DEPTH+1), count width
- Clk  input  1  clock; all state changes on the rising edge
- Rst  input  1  asynchronous, active-high reset
- PUSH  input  1  write dataIn onto the stack this cycle
- POP  input  1  remove the top entry this cycle
- dataIn  input  DATA_WIDTH  push data
- dataOut  output  DATA_WIDTH  registered popped data; holds its value until the next accepted pop
- dataValid  output  1  one-cycle pulse: dataOut was updated by an accepted pop
- TOP  output  DATA_WIDTH  combinational peek, equal to mem[COUNT-1]; 0 when EMPTY
- COUNT  output  CW  number of valid entries
- EMPTY  output  1  COUNT == 0
- FULL  output  1  COUNT == LIFO_DEPTH
- ALMOST_FULL  output  1  COUNT ≥ AF_LEVEL
- OVERFLOW  output  1  sticky; present only with LIFO_ERR_FLAGS_EN
- UNDERFLOW  output  1  sticky; present only with LIFO_ERR_FLAGS_EN

## Operation
The operation each cycle is decoded from {PUSH, POP} against the current state.
- IDLE (neither): no change; dataValid=0.
- PUSH only, !FULL: mem[COUNT]←dataIn, COUNT+1.
- PUSH only, FULL: ignored, no state change; counts as an overflow event.
- POP only, !EMPTY: dataOut←mem[COUNT-1], COUNT-1, dataValid=1 next cycle.
- POP only, EMPTY: ignored; dataOut holds its value, dataValid=0; counts as an underflow event.
- PUSH and POP, !EMPTY (REPLACE): dataOut←mem[COUNT-1], mem[COUNT-1]←dataIn, COUNT unchanged, dataValid=1. This is legal when FULL and is not an overflow.
- PUSH and POP, EMPTY: the push is performed (COUNT becomes 1); the pop is ignored and counts as an underflow event.
- Memory contents are not reset. Only COUNT, dataOut, dataValid and the error flags are reset.
- COUNT never wraps: it is bounded to the range 0 to LIFO_DEPTH by the rules above.

## Timing
- Reset values: COUNT=0, dataOut=0, dataValid=0, OVERFLOW=0, UNDERFLOW=0. This gives EMPTY=1, FULL=0, ALMOST_FULL=(AF_LEVEL==0), TOP=0.
- Assertion of Rst mid-operation clears state immediately and asynchronously; a PUSH or POP in the same cycle is lost.
- Pop latency: dataOut and dataValid are valid 1 cycle after the edge that accepts the pop.
- Push-to-TOP latency: TOP shows pushed data immediately after the accepting edge, with no bypass of dataIn.
- EMPTY, FULL, ALMOST_FULL and TOP are combinational from COUNT and memory.
- Back-to-back pops every cycle are supported at full rate.

## Configuration
- LIFO_ERR_FLAGS_EN defined:
  - OVERFLOW sets on any overflow event and UNDERFLOW sets on any underflow event, each on the following edge.
  - Both flags stay set until Rst.
- LIFO_ERR_FLAGS_EN undefined:
  - The OVERFLOW and UNDERFLOW ports and their logic are absent.
  - Ignored operations remain silently ignored.

## Structure
- Package lifo_pkg:
  - lifo_op_t enum {OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE}
  - function cnt_width(depth) returning $clog2(depth+1)
- One sub-module, lifo_op_decode:
  - Maps PUSH, POP, EMPTY and FULL to lifo_op_t plus ovf_evt and unf_evt.
  - Purely combinational.
- The top level holds the memory array, COUNT, the output registers and the flags.

## Test plan
- Reset, then push 0x11,0x22,0x33 and pop three times -> dataOut sequence 0x33,0x22,0x11, each with a one-cycle dataValid; final COUNT=0 and EMPTY=1.
- DEPTH=16, AF_LEVEL=14:
  - Push 16 values -> ALMOST_FULL rises at COUNT=14 and FULL at 16.
  - A 17th push leaves COUNT=16 and TOP unchanged, and OVERFLOW=1 when LIFO_ERR_FLAGS_EN is defined.
- When FULL with top 0xAA, assert PUSH+POP with dataIn 0x55 -> dataOut=0xAA, TOP=0x55, COUNT stays 16, no OVERFLOW.
- When EMPTY, assert PUSH+POP with dataIn 0x5A -> COUNT=1, TOP=0x5A, dataValid=0, UNDERFLOW=1 when the flags are enabled.
- Push 3 values, then assert Rst asynchronously between edges while POP=1 -> outputs return to their reset values at once and no dataValid pulse follows.
- DEPTH=5 (non-power-of-two): fill to 5 and drain to 0 with continuous POP -> 5 consecutive dataValid pulses in reverse order, and COUNT never exceeds 5 or wraps below 0.

Source files
------------

// File: rtl/lifo_pkg.sv
// -----------------------------------------------------------------------------
// lifo_pkg
//
// Shared types and helpers for the LIFO stack controller.
//
//   lifo_op_t  : the operation performed on the stack in a given cycle,
//                decoded from the PUSH/POP requests against EMPTY/FULL.
//   cnt_width  : number of bits needed to hold an occupancy count in the
//                range 0..depth inclusive.
// -----------------------------------------------------------------------------
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } lifo_op_t;

  // The count must represent "completely full" (== depth), hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_op_decode.sv
// -----------------------------------------------------------------------------
// lifo_op_decode
//
// Purely combinational decode of the per-cycle stack request.
//
// Ports:
//   push    in   push request
//   pop     in   pop request
//   empty   in   stack currently holds no entries
//   full    in   stack currently holds LIFO_DEPTH entries
//   op      out  operation actually carried out this cycle
//   ovf_evt out  a push was dropped because the stack was full
//   unf_evt out  a pop was dropped because the stack was empty
//
// Decode table ({push,pop}):
//   00            -> IDLE
//   10, !full     -> PUSH        10, full  -> IDLE + overflow event
//   01, !empty    -> POP         01, empty -> IDLE + underflow event
//   11, !empty    -> REPLACE (legal even when full, never an overflow)
//   11, empty     -> PUSH + underflow event (the pop half is dropped)
// -----------------------------------------------------------------------------
module lifo_op_decode
  import lifo_pkg::*;
(
  input  logic     push,
  input  logic     pop,
  input  logic     empty,
  input  logic     full,
  output lifo_op_t op,
  output logic     ovf_evt,
  output logic     unf_evt
);

  always_comb begin
    op      = OP_IDLE;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (full) begin
          ovf_evt = 1'b1;
        end else begin
          op = OP_PUSH;
        end
      end
      2'b01: begin
        if (empty) begin
          unf_evt = 1'b1;
        end else begin
          op = OP_POP;
        end
      end
      2'b11: begin
        if (empty) begin
          // Nothing to replace: keep the push, drop the pop.
          op      = OP_PUSH;
          unf_evt = 1'b1;
        end else begin
          op = OP_REPLACE;
        end
      end
      default: begin
        op = OP_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/lifo_stack_ctl.sv
// -----------------------------------------------------------------------------
// lifo_stack_ctl
//
// Parametrised last-in-first-out buffer with occupancy count, programmable
// almost-full threshold, top-of-stack replace (simultaneous push+pop) and a
// combinational peek of the current top entry.
//
// Parameters:
//   DATA_WIDTH  entry width in bits
//   LIFO_DEPTH  number of entries (>= 2, any value, not only powers of two)
//   AF_LEVEL    ALMOST_FULL asserts when COUNT >= AF_LEVEL
//   CW          (derived) width of COUNT, $clog2(LIFO_DEPTH+1)
//
// Ports:
//   Clk          in   clock, all state changes on the rising edge
//   Rst          in   asynchronous active-high reset
//   PUSH         in   write dataIn onto the stack
//   POP          in   remove the top entry
//   dataIn       in   push data
//   dataOut      out  registered popped data, held until the next accepted pop
//   dataValid    out  one-cycle pulse: dataOut was updated by an accepted pop
//   TOP          out  combinational peek of mem[COUNT-1], 0 when EMPTY
//   COUNT        out  number of valid entries
//   EMPTY        out  COUNT == 0
//   FULL         out  COUNT == LIFO_DEPTH
//   ALMOST_FULL  out  COUNT >= AF_LEVEL
//   OVERFLOW     out  sticky dropped-push flag   (only with LIFO_ERR_FLAGS_EN)
//   UNDERFLOW    out  sticky dropped-pop flag    (only with LIFO_ERR_FLAGS_EN)
//
// Optional feature macro: LIFO_ERR_FLAGS_EN adds the sticky OVERFLOW and
// UNDERFLOW outputs. Without it, dropped operations are silently ignored.
//
// Handshake: PUSH and POP are requests without a ready/backpressure signal.
// A request present at a rising edge is acted on at that edge if the stack
// state allows it; otherwise it is dropped (and reported as an event). The
// consumer sees popped data on dataOut qualified by the dataValid pulse one
// cycle after the accepting edge.
//
// The storage array is deliberately not reset; only COUNT, dataOut,
// dataValid and the error flags are.
// -----------------------------------------------------------------------------
module lifo_stack_ctl
  import lifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int LIFO_DEPTH = 16,
  parameter  int AF_LEVEL   = LIFO_DEPTH - 2,
  localparam int CW         = cnt_width(LIFO_DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic [DATA_WIDTH-1:0] TOP,
  output logic [CW-1:0]         COUNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_FULL
`ifdef LIFO_ERR_FLAGS_EN
  ,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
`endif
);

  // Address width for indexing the storage array.
  localparam int AW = (LIFO_DEPTH > 1) ? $clog2(LIFO_DEPTH) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [LIFO_DEPTH];

  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  data_valid_q;
  logic                  data_valid_d;

  // ---------------------------------------------------------------------------
  // Status derived from the count
  // ---------------------------------------------------------------------------
  logic          empty;
  logic          full;
  logic [AW-1:0] top_idx;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(LIFO_DEPTH));
  // Index of the current top entry; only meaningful when not empty.
  assign top_idx = AW'(count_q - CW'(1));

  // ---------------------------------------------------------------------------
  // Operation decode
  // ---------------------------------------------------------------------------
  lifo_op_t op;
  logic     ovf_evt;
  logic     unf_evt;

  lifo_op_decode u_op_decode (
    .push    (PUSH),
    .pop     (POP),
    .empty   (empty),
    .full    (full),
    .op      (op),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic          wr_en;
  logic [AW-1:0] wr_idx;

  always_comb begin
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = AW'(count_q);
    unique case (op)
      OP_PUSH: begin
        // Decode guarantees !full here, so count_q is a valid free slot.
        wr_en   = 1'b1;
        wr_idx  = AW'(count_q);
        count_d = count_q + CW'(1);
      end
      OP_POP: begin
        data_out_d   = mem_q[top_idx];
        data_valid_d = 1'b1;
        count_d      = count_q - CW'(1);
      end
      OP_REPLACE: begin
        // Old top leaves through dataOut while the new word takes its slot.
        data_out_d   = mem_q[top_idx];
        data_valid_d = 1'b1;
        wr_en        = 1'b1;
        wr_idx       = top_idx;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage has no reset: stale contents are never visible because TOP and
  // pops are gated by COUNT.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= dataIn;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dataOut     = data_out_q;
  assign dataValid   = data_valid_q;
  assign COUNT       = count_q;
  assign EMPTY       = empty;
  assign FULL        = full;
  assign ALMOST_FULL = (int'(count_q) >= AF_LEVEL);
  assign TOP         = empty ? '0 : mem_q[top_idx];

  // ---------------------------------------------------------------------------
  // Optional sticky error flags
  // ---------------------------------------------------------------------------
`ifdef LIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic ovf_d;
  logic unf_q;
  logic unf_d;

  always_comb begin
    ovf_d = ovf_q | ovf_evt;
    unf_d = unf_q | unf_evt;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;
`else
  // Events have no consumer in this build.
  logic unused_evt;
  assign unused_evt = ovf_evt | unf_evt;
`endif

endmodule

// File: tb/tb_lifo_stack_ctl.sv
// -----------------------------------------------------------------------------
// tb_lifo_stack_ctl
//
// Drives two stack instances (16 deep with AF_LEVEL=14, and 5 deep with the
// default threshold) and compares them against a simple array-plus-count
// stack model held in this bench.
// -----------------------------------------------------------------------------
module tb_lifo_stack_ctl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic       push16, pop16;
  logic [7:0] din16, dout16, top16;
  logic       dv16, empty16, full16, af16;
  logic [4:0] cnt16;

  logic       push5, pop5;
  logic [7:0] din5, dout5, top5;
  logic       dv5, empty5, full5, af5;
  logic [2:0] cnt5;

`ifdef LIFO_ERR_FLAGS_EN
  logic ovf16, unf16, ovf5, unf5;
`endif

  lifo_stack_ctl #(.DATA_WIDTH(8), .LIFO_DEPTH(16), .AF_LEVEL(14)) u_dut16 (
    .Clk         (clk),
    .Rst         (rst),
    .PUSH        (push16),
    .POP         (pop16),
    .dataIn      (din16),
    .dataOut     (dout16),
    .dataValid   (dv16),
    .TOP         (top16),
    .COUNT       (cnt16),
    .EMPTY       (empty16),
    .FULL        (full16),
    .ALMOST_FULL (af16)
`ifdef LIFO_ERR_FLAGS_EN
    ,
    .OVERFLOW    (ovf16),
    .UNDERFLOW   (unf16)
`endif
  );

  lifo_stack_ctl #(.DATA_WIDTH(8), .LIFO_DEPTH(5)) u_dut5 (
    .Clk         (clk),
    .Rst         (rst),
    .PUSH        (push5),
    .POP         (pop5),
    .dataIn      (din5),
    .dataOut     (dout5),
    .dataValid   (dv5),
    .TOP         (top5),
    .COUNT       (cnt5),
    .EMPTY       (empty5),
    .FULL        (full5),
    .ALMOST_FULL (af5)
`ifdef LIFO_ERR_FLAGS_EN
    ,
    .OVERFLOW    (ovf5),
    .UNDERFLOW   (unf5)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model: index 0 = 16-deep instance, 1 = 5-deep instance
  // ---------------------------------------------------------------------------
  int         dep [2] = '{16, 5};
  int         afl [2] = '{14, 3};
  logic [7:0] ms  [2][16];
  int         mc  [2];
  logic [7:0] ed  [2];
  logic       ev  [2];
  logic       eo  [2];
  logic       eu  [2];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] exp_top(input int s);
    return (mc[s] == 0) ? 8'h00 : ms[s][mc[s]-1];
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      mc[s] = 0; ed[s] = 8'h00; ev[s] = 1'b0; eo[s] = 1'b0; eu[s] = 1'b0;
    end
  endtask

  task automatic model_apply(input int s, input logic p, input logic o, input logic [7:0] d);
    ev[s] = 1'b0;
    if (p && o) begin
      if (mc[s] == 0) begin
        ms[s][0] = d; mc[s] = 1; eu[s] = 1'b1;
      end else begin
        ed[s] = ms[s][mc[s]-1]; ms[s][mc[s]-1] = d; ev[s] = 1'b1;
      end
    end else if (p) begin
      if (mc[s] == dep[s]) eo[s] = 1'b1;
      else begin ms[s][mc[s]] = d; mc[s] = mc[s] + 1; end
    end else if (o) begin
      if (mc[s] == 0) eu[s] = 1'b1;
      else begin mc[s] = mc[s] - 1; ed[s] = ms[s][mc[s]]; ev[s] = 1'b1; end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock cycle on instance s; returns 1 time unit after the edge.
  task automatic cycle(input int s, input logic p, input logic o, input logic [7:0] d);
    if (s == 0) begin push16 = p; pop16 = o; din16 = d; end
    else        begin push5  = p; pop5  = o; din5  = d; end
    @(posedge clk);
    model_apply(s, p, o, d);
    #1;
    push16 = 1'b0; pop16 = 1'b0; push5 = 1'b0; pop5 = 1'b0;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_clear();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    n_checks++; if (cnt16 !== 5'd0) begin n_fail++; $display("FAIL reset_count16: got %0d expected 0", cnt16); end
    n_checks++; if (empty16 !== 1'b1 || full16 !== 1'b0 || af16 !== 1'b0) begin n_fail++; $display("FAIL reset_flags16: got e=%b f=%b af=%b expected e=1 f=0 af=0", empty16, full16, af16); end
    n_checks++; if (top16 !== 8'h00 || dout16 !== 8'h00 || dv16 !== 1'b0) begin n_fail++; $display("FAIL reset_data16: got top=%h dout=%h dv=%b expected 00 00 0", top16, dout16, dv16); end
    n_checks++; if (cnt5 !== 3'd0 || empty5 !== 1'b1 || full5 !== 1'b0 || af5 !== 1'b0) begin n_fail++; $display("FAIL reset_state5: got c=%0d e=%b f=%b af=%b expected 0 1 0 0", cnt5, empty5, full5, af5); end
`ifdef LIFO_ERR_FLAGS_EN
    n_checks++; if (ovf16 !== 1'b0 || unf16 !== 1'b0) begin n_fail++; $display("FAIL reset_errflags: got ovf=%b unf=%b expected 0 0", ovf16, unf16); end
`endif
  endtask

  task automatic test_lifo_order();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) cycle(0, 1'b1, 1'b0, vals[i]);
    n_checks++; if (top16 !== 8'h33 || cnt16 !== 5'd3) begin n_fail++; $display("FAIL order_fill: got top=%h cnt=%0d expected 33 3", top16, cnt16); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'b0, 1'b1, 8'h00);
      n_checks++; if (dout16 !== vals[2-i] || dv16 !== 1'b1) begin n_fail++; $display("FAIL order_pop%0d: got dout=%h dv=%b expected %h 1", i, dout16, dv16, vals[2-i]); end
    end
    cycle(0, 1'b0, 1'b0, 8'h00);
    n_checks++; if (dv16 !== 1'b0 || dout16 !== 8'h11) begin n_fail++; $display("FAIL order_hold: got dout=%h dv=%b expected 11 0", dout16, dv16); end
    n_checks++; if (cnt16 !== 5'd0 || empty16 !== 1'b1) begin n_fail++; $display("FAIL order_empty: got cnt=%0d e=%b expected 0 1", cnt16, empty16); end
  endtask

  task automatic test_fill_replace_overflow();
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      d = (i == 15) ? 8'hAA : 8'($urandom_range(1, 254));
      cycle(0, 1'b1, 1'b0, d);
      n_checks++; if (cnt16 !== 5'(mc[0]) || top16 !== d) begin n_fail++; $display("FAIL fill_push%0d: got cnt=%0d top=%h expected %0d %h", i, cnt16, top16, mc[0], d); end
      n_checks++; if (af16 !== (mc[0] >= 14) || full16 !== (mc[0] == 16)) begin n_fail++; $display("FAIL fill_flags%0d: got af=%b f=%b expected %b %b", i, af16, full16, mc[0] >= 14, mc[0] == 16); end
    end
    // Replace on a full stack.
    cycle(0, 1'b1, 1'b1, 8'h55);
    n_checks++; if (dout16 !== 8'hAA || dv16 !== 1'b1) begin n_fail++; $display("FAIL replace_full_dout: got dout=%h dv=%b expected aa 1", dout16, dv16); end
    n_checks++; if (top16 !== 8'h55 || cnt16 !== 5'd16 || full16 !== 1'b1) begin n_fail++; $display("FAIL replace_full_state: got top=%h cnt=%0d f=%b expected 55 16 1", top16, cnt16, full16); end
`ifdef LIFO_ERR_FLAGS_EN
    n_checks++; if (ovf16 !== 1'b0) begin n_fail++; $display("FAIL replace_full_noovf: got ovf=%b expected 0", ovf16); end
`endif
    // 17th push is dropped.
    cycle(0, 1'b1, 1'b0, 8'h77);
    n_checks++; if (cnt16 !== 5'd16 || top16 !== 8'h55 || dv16 !== 1'b0) begin n_fail++; $display("FAIL overflow_push: got cnt=%0d top=%h dv=%b expected 16 55 0", cnt16, top16, dv16); end
`ifdef LIFO_ERR_FLAGS_EN
    n_checks++; if (ovf16 !== 1'b1 || unf16 !== 1'b0) begin n_fail++; $display("FAIL overflow_flag: got ovf=%b unf=%b expected 1 0", ovf16, unf16); end
`endif
  endtask

  task automatic test_replace_empty();
    do_reset();
    cycle(0, 1'b1, 1'b1, 8'h5A);
    n_checks++; if (cnt16 !== 5'd1 || top16 !== 8'h5A || empty16 !== 1'b0) begin n_fail++; $display("FAIL replace_empty_state: got cnt=%0d top=%h e=%b expected 1 5a 0", cnt16, top16, empty16); end
    n_checks++; if (dv16 !== 1'b0 || dout16 !== 8'h00) begin n_fail++; $display("FAIL replace_empty_dout: got dout=%h dv=%b expected 00 0", dout16, dv16); end
`ifdef LIFO_ERR_FLAGS_EN
    n_checks++; if (unf16 !== 1'b1 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL replace_empty_unf: got unf=%b ovf=%b expected 1 0", unf16, ovf16); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 1'b1, 1'b0, 8'(8'hC0 + i));
    cycle(0, 1'b0, 1'b1, 8'h00);
    n_checks++; if (dout16 !== 8'hC3 || cnt16 !== 5'd3) begin n_fail++; $display("FAIL areset_pre: got dout=%h cnt=%0d expected c3 3", dout16, cnt16); end
    // POP pending, then reset lands between edges.
    pop16 = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (cnt16 !== 5'd0 || empty16 !== 1'b1 || top16 !== 8'h00) begin n_fail++; $display("FAIL areset_immediate_state: got cnt=%0d e=%b top=%h expected 0 1 00", cnt16, empty16, top16); end
    n_checks++; if (dout16 !== 8'h00 || dv16 !== 1'b0) begin n_fail++; $display("FAIL areset_immediate_data: got dout=%h dv=%b expected 00 0", dout16, dv16); end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    pop16 = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    n_checks++; if (dv16 !== 1'b0 || cnt16 !== 5'd0 || dout16 !== 8'h00) begin n_fail++; $display("FAIL areset_after: got dv=%b cnt=%0d dout=%h expected 0 0 00", dv16, cnt16, dout16); end
  endtask

  task automatic test_random();
    int         pbias;
    logic       p, o;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pbias = ((i / 50) % 2 == 0) ? 75 : 30;
      p = ($urandom_range(0, 99) < pbias);
      o = ($urandom_range(0, 99) < (100 - pbias));
      d = 8'($urandom_range(0, 255));
      cycle(0, p, o, d);
      n_checks++; if (cnt16 !== 5'(mc[0])) begin n_fail++; $display("FAIL rand_count@%0d: got %0d expected %0d", i, cnt16, mc[0]); end
      n_checks++; if (top16 !== exp_top(0)) begin n_fail++; $display("FAIL rand_top@%0d: got %h expected %h", i, top16, exp_top(0)); end
      n_checks++; if (dv16 !== ev[0] || dout16 !== ed[0]) begin n_fail++; $display("FAIL rand_dout@%0d: got dout=%h dv=%b expected %h %b", i, dout16, dv16, ed[0], ev[0]); end
      n_checks++; if (empty16 !== (mc[0] == 0) || full16 !== (mc[0] == 16) || af16 !== (mc[0] >= afl[0])) begin n_fail++; $display("FAIL rand_flags@%0d: got e=%b f=%b af=%b cnt_model=%0d", i, empty16, full16, af16, mc[0]); end
`ifdef LIFO_ERR_FLAGS_EN
      n_checks++; if (ovf16 !== eo[0] || unf16 !== eu[0]) begin n_fail++; $display("FAIL rand_err@%0d: got ovf=%b unf=%b expected %b %b", i, ovf16, unf16, eo[0], eu[0]); end
`endif
    end
  endtask

  task automatic test_depth5();
    logic [7:0] vals [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      vals[i] = 8'($urandom_range(1, 255));
      cycle(1, 1'b1, 1'b0, vals[i]);
      n_checks++; if (cnt5 !== 3'(i + 1) || top5 !== vals[i] || af5 !== (i + 1 >= 3)) begin n_fail++; $display("FAIL d5_fill%0d: got cnt=%0d top=%h af=%b expected %0d %h %b", i, cnt5, top5, af5, i + 1, vals[i], i + 1 >= 3); end
    end
    cycle(1, 1'b1, 1'b0, 8'hEE);
    n_checks++; if (cnt5 !== 3'd5 || full5 !== 1'b1 || top5 !== vals[4]) begin n_fail++; $display("FAIL d5_overflow: got cnt=%0d f=%b top=%h expected 5 1 %h", cnt5, full5, top5, vals[4]); end
    // Continuous POP: five pulses then the stack stays at zero.
    pop5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      model_apply(1, 1'b0, 1'b1, 8'h00);
      #1;
      n_checks++; if (dv5 !== ev[1] || dout5 !== ed[1] || cnt5 !== 3'(mc[1])) begin n_fail++; $display("FAIL d5_drain%0d: got dv=%b dout=%h cnt=%0d expected %b %h %0d", i, dv5, dout5, cnt5, ev[1], ed[1], mc[1]); end
    end
    pop5 = 1'b0;
    n_checks++; if (dout5 !== vals[0] || empty5 !== 1'b1) begin n_fail++; $display("FAIL d5_final: got dout=%h e=%b expected %h 1", dout5, empty5, vals[0]); end
`ifdef LIFO_ERR_FLAGS_EN
    n_checks++; if (ovf5 !== 1'b1 || unf5 !== 1'b1) begin n_fail++; $display("FAIL d5_err: got ovf=%b unf=%b expected 1 1", ovf5, unf5); end
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    push16 = 1'b0; pop16 = 1'b0; din16 = 8'h00;
    push5  = 1'b0; pop5  = 1'b0; din5  = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    test_lifo_order();
    test_fill_replace_overflow();
    test_replace_empty();
    test_async_reset();
    test_random();
    test_depth5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
